// File: rtl/video_timing_pkg.sv
// Shared constants and payload types for the DVI raster timing path.
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIX_LAT  = 2;
    localparam int unsigned RGB_W        = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Activity flags (not pin levels) carried down the alignment delay line
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vtiming_t;

    localparam int unsigned TMDS_CH_BLUE   = 0;
    localparam int unsigned TMDS_CH_GREEN  = 1;
    localparam int unsigned TMDS_CH_RED    = 2;
    localparam logic [1:0]  TMDS_CTRL_TIED = 2'b00;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register chain; every stage resets to RESET_VAL.
module pipe_delay #(
    parameter int unsigned       WIDTH     = 3,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign o_q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates/fetch strobe out, pipeline-aligned
// DE/HSYNC/VSYNC plus colour and TMDS control terms back out after PIX_LATENCY+1.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter int unsigned PIX_LATENCY = DEF_PIX_LAT,
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W        = $clog2(H_TOTAL),
    localparam int unsigned Y_W        = $clog2(V_TOTAL)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic             o_fetch,
    output logic             o_line_start,
    output logic             o_frame_start,
    input  logic [RGB_W-1:0] i_rgb,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_ctrl_valid,
    output logic [1:0]       o_ctrl,
    output logic [7:0]       o_red,
    output logic [7:0]       o_green,
    output logic [7:0]       o_blue
);

    localparam int unsigned VT_W = $bits(vtiming_t);

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    if (PIX_LATENCY < 1 || PIX_LATENCY > 8) begin : g_bad_latency
        $error("video_timing_gen: PIX_LATENCY must be in 1..8");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("video_timing_gen: porch and sync lengths must be non-zero");
    end

    vtiming_t raw_c;
    vtiming_t tap;
    rgb_t     pix_c;
    logic     hs_pin_c;
    logic     vs_pin_c;

    // Raster counters; y advances on the x wrap edge, both may wrap together
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_x <= '0;
            o_y <= '0;
        end else if (o_x == X_LAST) begin
            o_x <= '0;
            o_y <= (o_y == Y_LAST) ? '0 : o_y + Y_W'(1);
        end else begin
            o_x <= o_x + X_W'(1);
        end
    end

    always_comb begin
        o_fetch       = (o_x < X_ACT) && (o_y < Y_ACT);
        o_line_start  = (o_x == '0);
        o_frame_start = (o_x == '0) && (o_y == '0);
        raw_c.de      = o_fetch;
        raw_c.hs      = (o_x >= HS_START) && (o_x < HS_END);
        raw_c.vs      = (o_y >= VS_START) && (o_y < VS_END);
    end

    pipe_delay #(
        .WIDTH     (VT_W),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL (VT_W'(0))
    ) u_timing_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (raw_c),
        .o_q   (tap)
    );

    always_comb begin
        pix_c    = i_rgb;
        hs_pin_c = tap.hs ? HS_POL : ~HS_POL;
        vs_pin_c = tap.vs ? VS_POL : ~VS_POL;
    end

    // Output register: tap and renderer pixel land together; colour blanked outside DE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_de         <= 1'b0;
            o_ctrl_valid <= 1'b1;
            o_hsync      <= ~HS_POL;
            o_vsync      <= ~VS_POL;
            o_ctrl       <= {~VS_POL, ~HS_POL};
            o_red        <= 8'h00;
            o_green      <= 8'h00;
            o_blue       <= 8'h00;
        end else begin
            o_de         <= tap.de;
            o_ctrl_valid <= ~tap.de;
            o_hsync      <= hs_pin_c;
            o_vsync      <= vs_pin_c;
            o_ctrl       <= {vs_pin_c, hs_pin_c};
            o_red        <= tap.de ? pix_c.r : 8'h00;
            o_green      <= tap.de ? pix_c.g : 8'h00;
            o_blue       <= tap.de ? pix_c.b : 8'h00;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: raster model compared every cycle on three configurations.
module tb_video_timing_gen;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, pl;
        bit hp, vp;
    } geom_t;

    typedef struct packed {
        logic [15:0] x, y;
        logic        fetch, ls, fs, de, hs, vs, cv;
        logic [1:0]  ctrl;
        logic [7:0]  r, g, b;
    } obs_t;

    localparam int SHT = 16 + 2 + 3 + 4;
    localparam int SVT = 6 + 2 + 2 + 3;
    localparam int SXW = $clog2(SHT);
    localparam int SYW = $clog2(SVT);

    geom_t G_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
    geom_t G_SM  = '{16, 2, 3, 4, 6, 2, 2, 3, 2, 1'b0, 1'b0};
    geom_t G_INV = '{16, 2, 3, 4, 6, 2, 2, 3, 1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k = 0;
    bit   in_rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   nprint = 0;

    always #5 clk = ~clk;

    // Default 640x480 instance
    logic [9:0] d_x;  logic [9:0] d_y;
    logic d_fetch, d_ls, d_fs, d_de, d_hs, d_vs, d_cv;
    logic [1:0] d_ctrl; logic [7:0] d_r, d_g, d_b; logic [23:0] d_rgb;
    // Small raster, PIX_LATENCY=2
    logic [SXW-1:0] s_x; logic [SYW-1:0] s_y;
    logic s_fetch, s_ls, s_fs, s_de, s_hs, s_vs, s_cv;
    logic [1:0] s_ctrl; logic [7:0] s_r, s_g, s_b; logic [23:0] s_rgb;
    // Small raster, PIX_LATENCY=1, active-high syncs
    logic [SXW-1:0] i_x; logic [SYW-1:0] i_y;
    logic i_fetch, i_ls, i_fs, i_de, i_hs, i_vs, i_cv;
    logic [1:0] i_ctrl; logic [7:0] i_r, i_g, i_b; logic [23:0] i_rgbv;

    video_timing_gen u_def (
        .i_clk(clk), .i_rst(rst), .o_x(d_x), .o_y(d_y), .o_fetch(d_fetch),
        .o_line_start(d_ls), .o_frame_start(d_fs), .i_rgb(d_rgb), .o_de(d_de),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_ctrl_valid(d_cv), .o_ctrl(d_ctrl),
        .o_red(d_r), .o_green(d_g), .o_blue(d_b));

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LATENCY(2)
    ) u_sm (
        .i_clk(clk), .i_rst(rst), .o_x(s_x), .o_y(s_y), .o_fetch(s_fetch),
        .o_line_start(s_ls), .o_frame_start(s_fs), .i_rgb(s_rgb), .o_de(s_de),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_ctrl_valid(s_cv), .o_ctrl(s_ctrl),
        .o_red(s_r), .o_green(s_g), .o_blue(s_b));

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LATENCY(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_inv (
        .i_clk(clk), .i_rst(rst), .o_x(i_x), .o_y(i_y), .o_fetch(i_fetch),
        .o_line_start(i_ls), .o_frame_start(i_fs), .i_rgb(i_rgbv), .o_de(i_de),
        .o_hsync(i_hs), .o_vsync(i_vs), .o_ctrl_valid(i_cv), .o_ctrl(i_ctrl),
        .o_red(i_r), .o_green(i_g), .o_blue(i_b));

    // Expected observation k cycles after reset release (k=0 also covers reset itself)
    function automatic obs_t model(input int kk, input geom_t g);
        obs_t o;
        int ht, vt, x, y, j, xj, yj;
        bit hsa, vsa;
        ht = g.ha + g.hfp + g.hsy + g.hbp;
        vt = g.va + g.vfp + g.vsy + g.vbp;
        x = kk % ht;
        y = (kk / ht) % vt;
        o = '0;
        o.x = 16'(x);
        o.y = 16'(y);
        o.fetch = (x < g.ha) && (y < g.va);
        o.ls = (x == 0);
        o.fs = (x == 0) && (y == 0);
        hsa = 1'b0;
        vsa = 1'b0;
        j = kk - g.pl - 1;
        xj = 0;
        yj = 0;
        if (j >= 0) begin
            xj = j % ht;
            yj = (j / ht) % vt;
            o.de = (xj < g.ha) && (yj < g.va);
            hsa = (xj >= g.ha + g.hfp) && (xj < g.ha + g.hfp + g.hsy);
            vsa = (yj >= g.va + g.vfp) && (yj < g.va + g.vfp + g.vsy);
        end
        o.hs = hsa ? g.hp : !g.hp;
        o.vs = vsa ? g.vp : !g.vp;
        o.cv = !o.de;
        o.ctrl = {o.vs, o.hs};
        o.r = o.de ? 8'(xj) : 8'h00;
        o.g = o.de ? 8'(yj) : 8'h00;
        o.b = o.de ? 8'hA5 : 8'h00;
        return o;
    endfunction

    // Renderer: pixel for the fetch issued pl cycles ago, junk otherwise
    function automatic logic [23:0] rgb_for(input int kk, input geom_t g);
        int ht, vt, j, x, y;
        ht = g.ha + g.hfp + g.hsy + g.hbp;
        vt = g.va + g.vfp + g.vsy + g.vbp;
        j = kk - g.pl;
        if (j < 0) return 24'h5AC33C;
        x = j % ht;
        y = (j / ht) % vt;
        if (x < g.ha && y < g.va) return {8'(x), 8'(y), 8'hA5};
        return 24'h5AC33C;
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (nprint < 30) begin
                nprint++;
                $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, exp);
            end
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (nprint < 30) begin
                nprint++;
                $display("FAIL %s k=%0d actual=%0d required=%0d", nm, k, act, exp);
            end
        end
    endtask

    task automatic drive();
        d_rgb  = rgb_for(k, G_DEF);
        s_rgb  = rgb_for(k, G_SM);
        i_rgbv = rgb_for(k, G_INV);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!in_rst) k++;
        drive();
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        lit("rst_def_x", int'(d_x), 0);
        lit("rst_def_y", int'(d_y), 0);
        lit("rst_def_de", int'(d_de), 0);
        lit("rst_def_ctrl_valid", int'(d_cv), 1);
        lit("rst_def_ctrl", int'(d_ctrl), 3);
        lit("rst_def_colour", int'({d_r, d_g, d_b}), 0);
        lit("rst_inv_ctrl", int'(i_ctrl), 0);
        lit("rst_sm_x", int'(s_x), 0);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        cmp("def", '{16'(d_x), 16'(d_y), d_fetch, d_ls, d_fs, d_de, d_hs, d_vs, d_cv,
                     d_ctrl, d_r, d_g, d_b}, model(k, G_DEF));
        cmp("sm",  '{16'(s_x), 16'(s_y), s_fetch, s_ls, s_fs, s_de, s_hs, s_vs, s_cv,
                     s_ctrl, s_r, s_g, s_b}, model(k, G_SM));
        cmp("inv", '{16'(i_x), 16'(i_y), i_fetch, i_ls, i_fs, i_de, i_hs, i_vs, i_cv,
                     i_ctrl, i_r, i_g, i_b}, model(k, G_INV));
    end

    // Per-line and per-frame aggregate counts
    int dfetch, dhlow, s_cyc, s_lines, s_delines, s_vlow;
    logic s_de_q;
    always @(negedge clk) begin
        if (rst) begin
            dfetch = 0; dhlow = 0; s_cyc = 0; s_lines = 0; s_delines = 0; s_vlow = 0;
            s_de_q = 1'b0;
        end else begin
            if (d_ls && k > 0) begin
                lit("def_fetch_per_line", dfetch, 640);
                lit("def_hsync_low_per_line", dhlow, 96);
                dfetch = 0;
                dhlow = 0;
            end
            dfetch += int'(d_fetch);
            dhlow += int'(!d_hs);
            if (s_fs && k > 0) begin
                lit("sm_frame_period", s_cyc, 325);
                lit("sm_lines_per_frame", s_lines, 13);
                lit("sm_de_lines", s_delines, 6);
                lit("sm_vsync_low", s_vlow, 50);
                s_cyc = 0; s_lines = 0; s_delines = 0; s_vlow = 0;
            end
            s_cyc++;
            s_lines += int'(s_ls);
            s_delines += int'(s_de && !s_de_q);
            s_vlow += int'(!s_vs);
            s_de_q = s_de;
        end
    end

    initial begin
        drive();
        repeat (5) step();
        @(negedge clk);
        check_reset_vals();

        @(posedge clk); #1;
        rst = 1'b0;
        in_rst = 1'b0;
        drive();

        run_to(2);
        lit("inv_first_de", int'(i_de), 1);
        lit("sm_de_not_yet", int'(s_de), 0);
        lit("def_de_not_yet", int'(d_de), 0);
        run_to(3);
        lit("def_first_de", int'(d_de), 1);
        lit("def_first_red", int'(d_r), 0);
        lit("def_first_blue", int'(d_b), 8'hA5);
        run_to(201);
        lit("inv_vsync_pre", int'(i_vs), 0);
        run_to(202);
        lit("sm_vsync_pre", int'(s_vs), 1);
        lit("inv_vsync_act", int'(i_vs), 1);
        run_to(203);
        lit("sm_vsync_act", int'(s_vs), 0);
        lit("sm_ctrl_vsync", int'(s_ctrl), 1);
        run_to(324);
        lit("sm_fs_pre", int'(s_fs), 0);
        run_to(325);
        lit("sm_fs_wrap", int'(s_fs), 1);
        run_to(642);
        lit("def_de_last", int'(d_de), 1);
        lit("def_red_last", int'(d_r), 8'(639));
        run_to(643);
        lit("def_de_off", int'(d_de), 0);
        run_to(658);
        lit("def_hs_pre", int'(d_hs), 1);
        run_to(659);
        lit("def_hs_fall", int'(d_hs), 0);
        lit("def_ctrl_hsync", int'(d_ctrl), 2);
        run_to(754);
        lit("def_hs_last", int'(d_hs), 0);
        run_to(755);
        lit("def_hs_rise", int'(d_hs), 1);

        run_to(2355);
        lit("sm_mid_x", int'(s_x), 5);
        lit("sm_mid_y", int'(s_y), 3);
        lit("sm_mid_de", int'(s_de), 1);

        @(posedge clk); #1;
        rst = 1'b1;
        in_rst = 1'b1;
        k = 0;
        drive();
        repeat (4) step();
        @(negedge clk);
        check_reset_vals();

        @(posedge clk); #1;
        rst = 1'b0;
        in_rst = 1'b0;
        drive();
        @(negedge clk);
        lit("re_def_fs", int'(d_fs), 1);
        lit("re_sm_fs", int'(s_fs), 1);
        lit("re_sm_de", int'(s_de), 0);
        run_to(2);
        lit("re_sm_de_blank", int'(s_de), 0);
        lit("re_inv_de", int'(i_de), 1);
        run_to(3);
        lit("re_sm_de_first", int'(s_de), 1);
        lit("re_sm_red", int'(s_r), 0);
        lit("re_sm_green", int'(s_g), 0);
        run_to(700);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
